// File: rtl/uint16_bcd_converter_if.sv
// Handshake bundle between the calculator stage, the BCD converter and the display.
// valid/ready: a transfer happens on a rising edge where valid=1 and ready=1; valid holds its payload until then.
interface uint16_bcd_converter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] value;
    logic        invalid_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] digits;
    logic        out_error;

    modport master (
        output in_valid, value, invalid_in, out_ready,
        input  in_ready, out_valid, digits, out_error
    );

    modport slave (
        input  in_valid, value, invalid_in, out_ready,
        output in_ready, out_valid, digits, out_error
    );
endinterface

// File: rtl/uint16_bcd_converter.sv
// Sequential double-dabble converter: 16-bit unsigned value -> five BCD digits in 16 shift cycles.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module uint16_bcd_converter #(
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uint16_bcd_converter_if.slave       bus,
    output logic [1:0]                  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] shift_q, shift_n;
    logic [19:0] bcd_q, bcd_n, bcd_adj;
    logic [4:0]  cnt_q;
    logic [19:0] digits_q, final_digits;
    logic        err_q;
    logic        accept, last_step;

    // One double-dabble step: correct nibbles >= 5, then shift the joint register left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_n, shift_n} = {bcd_adj[18:0], shift_q, 1'b0};
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    function automatic logic [19:0] blank_leading(input logic [19:0] d);
        logic lead;
        lead          = 1'b1;
        blank_leading = d;
        for (int i = 4; i >= 1; i--) begin
            if (lead && d[4*i +: 4] == 4'd0)
                blank_leading[4*i +: 4] = BLANK_CODE;
            else
                lead = 1'b0;
        end
    endfunction

    assign final_digits = blank_leading(bcd_n);
`else
    assign final_digits = bcd_n;
`endif

    always_comb begin
        state_n      = state_q;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        accept       = 1'b0;
        last_step    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = rst_n;
                if (bus.in_valid && rst_n) begin
                    accept  = 1'b1;
                    state_n = bus.invalid_in ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd15) begin
                    last_step = 1'b1;
                    state_n   = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            shift_q <= bus.value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            // An upstream-invalid result skips conversion and is never blanked.
            if (bus.invalid_in) begin
                digits_q <= '0;
                err_q    <= 1'b1;
            end
        end else if (state_q == SHIFT) begin
            shift_q <= shift_n;
            bcd_q   <= bcd_n;
            cnt_q   <= cnt_q + 5'd1;
            if (last_step) begin
                digits_q <= final_digits;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.digits    = digits_q;
    assign bus.out_error = err_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_uint16_bcd_converter.sv
// Bench for uint16_bcd_converter: directed corner cases plus a randomized sweep
// checked against a decimal reference model.
module tb_uint16_bcd_converter;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         SWEEP_N    = 2000;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    uint16_bcd_converter_if bus();

    uint16_bcd_converter #(.BLANK_CODE(BLANK_CODE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    logic [20:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: {out_error, digits} from plain decimal arithmetic
    function automatic logic [20:0] ref_result(input logic [15:0] v, input logic inv);
        logic [19:0] d;
        int          n;
        logic        lead;
        if (inv) return {1'b1, 20'h0};
        n = int'(v);
        for (int i = 0; i < 5; i++) begin
            d[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            if (lead && d[4*i +: 4] == 4'd0) d[4*i +: 4] = BLANK_CODE;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return {1'b0, d};
    endfunction

    // driver: one full conversion with latency and handshake checks
    task automatic convert(input logic [15:0] v, input logic inv, input int exp_lat);
        int          lat;
        logic [20:0] e;
        e = ref_result(v, inv);
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid   = 1'b1;
        bus.value      = v;
        bus.invalid_in = inv;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.value      = 16'($urandom);
        bus.invalid_in = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("digits", bus.digits, e[19:0]);
        check("out_error", bus.out_error, e[20]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", bus.out_valid, 0);
        check("in_ready_after_hs", bus.in_ready, 1);
    endtask

    task automatic backpressure(input logic [15:0] v);
        int          waited;
        logic [20:0] e;
        e = ref_result(v, 1'b0);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.value      = v;
        bus.invalid_in = 1'b0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        waited = 0;
        while (!bus.out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("bp_reach_done", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid   = 1'($urandom);
            bus.value      = 16'($urandom);
            bus.invalid_in = 1'($urandom);
            check("bp_digits_stable", bus.digits, e[19:0]);
            check("bp_in_ready_low", bus.in_ready, 0);
            check("bp_out_valid_held", bus.out_valid, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_consumed", bus.out_valid, 0);
        check("bp_in_ready_after", bus.in_ready, 1);
    endtask

    function automatic logic [15:0] pick_value();
        case ($urandom_range(0, 15))
            0: return 16'd0;
            1: return 16'd65535;
            2: return 16'($urandom_range(0, 9));
            3: return 16'(10 ** $urandom_range(1, 4));
            4: return 16'(10 ** $urandom_range(1, 4) - 1);
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.value      = '0;
        bus.invalid_in = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_digits", bus.digits, 0);
        check("rst_out_error", bus.out_error, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        convert(16'd0, 1'b0, 16);
        convert(16'd65535, 1'b0, 16);
        convert(16'd1234, 1'b0, 16);
        convert(16'd10000, 1'b0, 16);
        convert(16'd777, 1'b1, 0);
        convert(16'd9, 1'b0, 16);
        backpressure(16'd4321);

        // abort a conversion with reset after 8 shift steps
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.value    = 16'd999;
        bus.invalid_in = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_digits", bus.digits, 0);
        check("abort_out_error", bus.out_error, 0);
        check("abort_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(16'd42, 1'b0, 16);

        // randomized sweep with gaps on both sides
        fork
            begin : producer
                logic [15:0] v;
                logic        inv;
                int          waited;
                for (int k = 0; k < SWEEP_N; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    v   = pick_value();
                    inv = ($urandom_range(0, 15) == 0);
                    bus.in_valid   = 1'b1;
                    bus.value      = v;
                    bus.invalid_in = inv;
                    waited = 0;
                    while (!bus.in_ready && waited < 200) begin
                        @(negedge clk);
                        waited++;
                    end
                    if (!bus.in_ready) begin
                        check("sweep_accept_timeout", 0, 1);
                        break;
                    end
                    exp_q.push_back(ref_result(v, inv));
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
                bus.in_valid = 1'b0;
            end
            begin : consumer
                int          got;
                int          cyc;
                logic [20:0] e;
                got = 0;
                cyc = 0;
                while (got < SWEEP_N && cyc < 90000) begin
                    @(negedge clk);
                    cyc++;
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("sweep_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("sweep_result", {bus.out_error, bus.digits}, e);
                        end
                        got++;
                    end
                end
                bus.out_ready = 1'b0;
                check("sweep_count", got, SWEEP_N);
            end
        join
        check("sweep_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/uint16_bcd_converter.md
UINT16_BCD_CONVERTER -- requirements
Module: uint16_bcd_converter

Interface
REQ-001 Parameter BLANK_CODE, default 4'hF: nibble code driven on a blanked digit position.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port in_valid  input  1  upstream calculator result is present.
REQ-005 Port in_ready  output  1  block can accept a result this cycle.
REQ-006 Port value  input  16  unsigned result from the calculator stage.
REQ-007 Port invalid_in  input  1  calculator's invalid_input flag for this result.
REQ-008 Port out_valid  output  1  digits/out_error hold a finished conversion.
REQ-009 Port out_ready  input  1  downstream display consumes the conversion.
REQ-010 Port digits  output  20  five BCD nibbles; [19:16] = ten-thousands ... [3:0] = units.
REQ-011 Port out_error  output  1  conversion carries the upstream invalid flag.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept happens on an edge with in_valid=1 and in_ready=1. value and invalid_in SHALL be captured at that edge.
REQ-015 Accept with invalid_in=0: IDLE->SHIFT. The 16-bit shift register SHALL load value, the 20-bit BCD register SHALL clear, and the 5-bit counter SHALL clear.
REQ-016 Accept with invalid_in=1: IDLE->DONE on the same edge. Outputs SHALL be out_error=1 and digits=20'h0. Blanking SHALL NOT apply to this result.
REQ-017 Each SHIFT edge SHALL perform one double-dabble step:
- add 3 to every BCD nibble >=5;
- then shift {bcd,bin} left by one;
- increment the counter.
REQ-018 On the 16th SHIFT edge (counter==15):
- the state SHALL go SHIFT->DONE;
- digits SHALL register the final BCD value;
- out_error SHALL be 0.
REQ-019 Latency, valid input: accept on edge k, out_valid=1 after edge k+16. Latency, invalid input: out_valid=1 after edge k.
REQ-020 In DONE, digits, out_error and out_valid SHALL hold stable until an edge with out_ready=1. That edge SHALL move DONE->IDLE.
REQ-021 in_ready SHALL be 1 in the cycle after the out handshake. There is no bypass: at most one conversion is in flight, and peak throughput is one result per 18 cycles.
REQ-022 in_valid, value and invalid_in SHALL be ignored outside IDLE. out_ready SHALL be ignored outside DONE.
REQ-023 All 65536 inputs SHALL convert exactly. Maximum 65535 -> 6,5,5,3,5. No nibble SHALL ever exceed 9 except BLANK_CODE.

Reset
REQ-024 rst_n=0 SHALL immediately force the following, regardless of state, including mid-SHIFT:
- state=IDLE;
- shift, BCD and counter registers cleared;
- digits=0, out_error=0, out_valid=0.
REQ-025 While rst_n=0, in_ready SHALL be 0. After rst_n deasserts, in_ready SHALL be 1 in IDLE. A conversion aborted by reset SHALL never be presented.

Configuration
REQ-026 Macro BCD_LEADING_ZERO_BLANK_EN SHALL select leading-zero blanking.
REQ-027 With BCD_LEADING_ZERO_BLANK_EN defined:
- at the SHIFT->DONE load, every leading zero nibble above the most significant non-zero digit SHALL be replaced by BLANK_CODE;
- the units nibble SHALL never be blanked;
- latency SHALL be unchanged.
REQ-028 Without BCD_LEADING_ZERO_BLANK_EN, digits SHALL be plain zero-padded BCD and no blanking logic SHALL be synthesized.

Verification
REQ-029 Input value=0, invalid_in=0, out_ready=1 -> out_valid after exactly 16 edges; digits=20'h00000, out_error=0. With _EN defined: digits=20'hFFFF0.
REQ-030 Input value=65535 -> digits=20'h65535. Then value=1234 -> 20'h01234, or 20'hF1234 with _EN defined. Then value=10000 -> 20'h10000.
REQ-031 Input value=777, invalid_in=1 -> out_valid after the accept edge; out_error=1, digits=0. in_ready=1 one cycle after the out handshake.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles after out_valid, while toggling in_valid/value -> digits stable, in_ready=0. The result is consumed on the first edge with out_ready=1.
REQ-033 Pulse rst_n low at SHIFT counter=8 -> all outputs 0 immediately. Then a new accept of value=42 -> digits=20'h00042 after 16 edges, with no residue from the aborted conversion.
REQ-034 Random sweep of 2000 values with random in_valid/out_ready gaps -> every accepted value is presented exactly once, in order, and matches a reference decimal model.
